// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the byte-wide memory port arbiter.
//   ADDR_LEN      default byte address width
//   SIZE_B/H/W    MEM access size encodings (2'b11 is treated as a word)
//   state_t       arbiter state encoding
//   byte_count()  number of byte accesses needed for a MEM size
package mem_arbiter_pkg;

  localparam int ADDR_LEN = 32;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    IF_RD  = 3'd1,
    MEM_RD = 3'd2,
    MEM_WR = 3'd3,
    TURN   = 3'd4
  } state_t;

  // Byte count for a MEM size; the reserved code 2'b11 behaves like a word.
  function automatic logic [2:0] byte_count(input logic [1:0] size);
    case (size)
      SIZE_B:  byte_count = 3'd1;
      SIZE_H:  byte_count = 3'd2;
      SIZE_W:  byte_count = 3'd4;
      default: byte_count = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_byte_assembler.sv
// Byte sequencing datapath for the arbiter.
//   clk, rst   clock and asynchronous active-high reset
//   clear      start of a transaction: counter and assembly word to zero
//   advance    step the byte counter
//   capture    store din into the assembly word at lane cnt-1
//   din        read byte from memory
//   wdata      latched store data; wsel picks the byte driven as wbyte
//   cnt        byte counter (0..5)
//   word_next  assembly word with din already placed at lane cnt-1
module mem_byte_assembler (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        advance,
  input  logic        capture,
  input  logic [7:0]  din,
  input  logic [31:0] wdata,
  input  logic [1:0]  wsel,
  output logic [2:0]  cnt,
  output logic [7:0]  wbyte,
  output logic [31:0] word_next
);

  logic [31:0] word;
  logic [1:0]  lane;

  // The byte arriving now was addressed one cycle earlier, hence cnt-1.
  // For cnt=4 the low two bits wrap to lane 3 as intended.
  assign lane  = cnt[1:0] - 2'd1;
  assign wbyte = wdata[{wsel, 3'b000} +: 8];

  // Little-endian placement of the incoming read byte.
  always_comb begin
    word_next = word;
    word_next[{lane, 3'b000} +: 8] = din;
  end

  // Byte counter and assembly register; cleared at every grant so unused upper bytes read as zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= 3'd0;
      word <= 32'h0000_0000;
    end else if (clear) begin
      cnt  <= 3'd0;
      word <= 32'h0000_0000;
    end else begin
      if (advance) cnt  <= cnt + 3'd1;
      if (capture) word <= word_next;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter and byte sequencer for the single byte-wide synchronous memory port.
// IF (32-bit reads) and MEM (1/2/4-byte reads/writes) share the port; multi-byte
// requests are split into byte accesses and reads are reassembled little-endian.
//
// Ports:
//   clk_in, rst_in              clock, asynchronous active-high reset
//   if_req_i/if_addr_i          IF fetch request and byte address
//   if_flush_i                  abort IF fetch / block IF grant
//   if_done_o/if_data_o         IF completion pulse and fetched word
//   mem_req_i/mem_we_i          MEM request and write enable
//   mem_size_i/mem_addr_i       MEM size code and byte address
//   mem_wdata_i                 MEM store data (low bytes used)
//   mem_done_o/mem_rdata_o      MEM completion pulse and zero-extended load data
//   ram_addr_o/ram_wr_o         memory byte address and write strobe
//   ram_dout_o/ram_din_i        memory write byte / read byte (valid one cycle after address)
//
// Build option: define ARB_ROUND_ROBIN_EN to alternate grants on simultaneous
// requests; otherwise MEM always wins over IF. ADDR_W must be at least 2.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = ADDR_LEN
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  input  logic              if_flush_i,
  output logic              if_done_o,
  output logic [31:0]       if_data_o,
  input  logic              mem_req_i,
  input  logic              mem_we_i,
  input  logic [1:0]        mem_size_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [31:0]       mem_wdata_i,
  output logic              mem_done_o,
  output logic [31:0]       mem_rdata_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic              ram_wr_o,
  output logic [7:0]        ram_dout_o,
  input  logic [7:0]        ram_din_i
);

  state_t            state;
  state_t            state_next;
  logic [2:0]        nbytes;
  logic [31:0]       store_data;
  logic [2:0]        cnt;
  logic [7:0]        wbyte;
  logic [31:0]       word_next;
  logic              clear;
  logic              advance;
  logic              capture;
  logic              grant_if;
  logic              grant_mem;
  logic              mem_first;
  logic              rd_finish;
  logic              wr_more;
  logic              wr_last;
  logic [ADDR_W-1:0] addr_one;

  assign addr_one = {{(ADDR_W-1){1'b0}}, 1'b1};
  assign wr_last  = (state == MEM_WR) && (cnt + 3'd1 == nbytes);

`ifdef ARB_ROUND_ROBIN_EN
  logic last_if;

  // Remember who completed last; a flushed fetch never completes and does not count.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      last_if <= 1'b1;
    end else if (rd_finish || wr_last) begin
      last_if <= (state == IF_RD);
    end
  end

  assign mem_first = last_if;
`else
  assign mem_first = 1'b1;
`endif

  mem_byte_assembler u_asm (
    .clk       (clk_in),
    .rst       (rst_in),
    .clear     (clear),
    .advance   (advance),
    .capture   (capture),
    .din       (ram_din_i),
    .wdata     (store_data),
    .wsel      (cnt[1:0] + 2'd1),
    .cnt       (cnt),
    .wbyte     (wbyte),
    .word_next (word_next)
  );

  // State register.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Arbitration, next state and byte-sequencing controls.
  // Read timeline: cnt=k drives address k; bytes land while cnt=1..N; the done
  // cycle runs with cnt=N+1 and is followed by exactly one TURN cycle.
  always_comb begin
    state_next = state;
    clear      = 1'b0;
    advance    = 1'b0;
    capture    = 1'b0;
    grant_if   = 1'b0;
    grant_mem  = 1'b0;
    rd_finish  = 1'b0;
    wr_more    = 1'b0;
    case (state)
      IDLE: begin
        if (mem_req_i && (mem_first || !if_req_i || if_flush_i)) begin
          grant_mem  = 1'b1;
          clear      = 1'b1;
          state_next = mem_we_i ? MEM_WR : MEM_RD;
        end else if (if_req_i && !if_flush_i) begin
          grant_if   = 1'b1;
          clear      = 1'b1;
          state_next = IF_RD;
        end else begin
          state_next = IDLE;
        end
      end
      IF_RD, MEM_RD: begin
        if ((state == IF_RD) && if_flush_i) begin
          state_next = TURN;
        end else if (cnt == nbytes + 3'd1) begin
          state_next = TURN;
        end else if (cnt == nbytes) begin
          capture    = 1'b1;
          rd_finish  = 1'b1;
          advance    = 1'b1;
        end else begin
          capture    = (cnt != 3'd0);
          advance    = 1'b1;
        end
      end
      MEM_WR: begin
        if (wr_last) begin
          state_next = TURN;
        end else begin
          advance    = 1'b1;
          wr_more    = 1'b1;
        end
      end
      TURN: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Registered port outputs and latched request fields.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      nbytes      <= 3'd0;
      store_data  <= 32'h0000_0000;
      ram_addr_o  <= {ADDR_W{1'b0}};
      ram_wr_o    <= 1'b0;
      ram_dout_o  <= 8'h00;
      if_done_o   <= 1'b0;
      mem_done_o  <= 1'b0;
      if_data_o   <= 32'h0000_0000;
      mem_rdata_o <= 32'h0000_0000;
    end else begin
      ram_wr_o   <= 1'b0;
      if_done_o  <= 1'b0;
      mem_done_o <= 1'b0;

      if (grant_mem) begin
        nbytes     <= byte_count(mem_size_i);
        store_data <= mem_wdata_i;
        ram_addr_o <= mem_addr_i;
        ram_wr_o   <= mem_we_i;
        if (mem_we_i) ram_dout_o <= mem_wdata_i[7:0];
        // A single-byte store completes together with its only byte.
        mem_done_o <= mem_we_i && (byte_count(mem_size_i) == 3'd1);
      end else if (grant_if) begin
        nbytes     <= 3'd4;
        ram_addr_o <= if_addr_i;
      end

      // Address steps only while bytes remain; it then holds its last value.
      if (advance && (cnt + 3'd1 < nbytes)) begin
        ram_addr_o <= ram_addr_o + addr_one;
      end

      if (wr_more) begin
        ram_wr_o   <= 1'b1;
        ram_dout_o <= wbyte;
        mem_done_o <= (cnt + 3'd2 == nbytes);
      end

      if (rd_finish) begin
        if (state == IF_RD) begin
          if_done_o <= 1'b1;
          if_data_o <= word_next;
        end else begin
          mem_done_o  <= 1'b1;
          mem_rdata_o <= word_next;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with a small synchronous byte memory model.
module tb_mem_arbiter;

`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic        if_flush_i;
  logic        if_done_o;
  logic [31:0] if_data_o;
  logic        mem_req_i;
  logic        mem_we_i;
  logic [1:0]  mem_size_i;
  logic [31:0] mem_addr_i;
  logic [31:0] mem_wdata_i;
  logic        mem_done_o;
  logic [31:0] mem_rdata_o;
  logic [31:0] ram_addr_o;
  logic        ram_wr_o;
  logic [7:0]  ram_dout_o;
  logic [7:0]  ram_din_i;

  int errors = 0;
  int checks = 0;

  logic [31:0] wr_addr [0:63];
  logic [7:0]  wr_data [0:63];
  int          wr_cnt = 0;

  mem_arbiter #(.ADDR_W(32)) dut (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .if_req_i    (if_req_i),
    .if_addr_i   (if_addr_i),
    .if_flush_i  (if_flush_i),
    .if_done_o   (if_done_o),
    .if_data_o   (if_data_o),
    .mem_req_i   (mem_req_i),
    .mem_we_i    (mem_we_i),
    .mem_size_i  (mem_size_i),
    .mem_addr_i  (mem_addr_i),
    .mem_wdata_i (mem_wdata_i),
    .mem_done_o  (mem_done_o),
    .mem_rdata_o (mem_rdata_o),
    .ram_addr_o  (ram_addr_o),
    .ram_wr_o    (ram_wr_o),
    .ram_dout_o  (ram_dout_o),
    .ram_din_i   (ram_din_i)
  );

  always #5 clk_in = ~clk_in;

  // Memory contents: a few fixed words, everything else is low address byte + 0x40.
  function automatic logic [7:0] rd_byte(input logic [31:0] a);
    case (a)
      32'h0000_0100: rd_byte = 8'h13;
      32'h0000_0101: rd_byte = 8'h05;
      32'h0000_0102: rd_byte = 8'h00;
      32'h0000_0103: rd_byte = 8'h00;
      32'h0000_1000: rd_byte = 8'hEF;
      32'h0000_1001: rd_byte = 8'hBE;
      32'h0000_1002: rd_byte = 8'hAD;
      32'h0000_1003: rd_byte = 8'hDE;
      32'hFFFF_FFFF: rd_byte = 8'h80;
      32'h0000_0000: rd_byte = 8'h7F;
      default:       rd_byte = a[7:0] + 8'h40;
    endcase
  endfunction

  // Synchronous read (data the cycle after the address) and a log of every write strobe.
  always @(posedge clk_in) begin
    ram_din_i <= rd_byte(ram_addr_o);
    if (ram_wr_o) begin
      wr_addr[wr_cnt] <= ram_addr_o;
      wr_data[wr_cnt] <= ram_dout_o;
      wr_cnt          <= wr_cnt + 1;
    end
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  // Advance edge by edge until the selected done pulse is seen or the budget runs out.
  task automatic wait_done(input int which, input int limit, output int n);
    logic hit;
    n   = 0;
    hit = 1'b0;
    while (!hit && n < limit) begin
      tick();
      n++;
      case (which)
        0:       hit = if_done_o;
        1:       hit = mem_done_o;
        default: hit = if_done_o | mem_done_o;
      endcase
    end
  endtask

  task automatic test_reset();
    rst_in = 1'b1; if_req_i = 1'b0; if_addr_i = 32'h0; if_flush_i = 1'b0;
    mem_req_i = 1'b0; mem_we_i = 1'b0; mem_size_i = 2'b00; mem_addr_i = 32'h0; mem_wdata_i = 32'h0;
    tick(); tick();
    checks++; if (ram_wr_o !== 1'b0) begin errors++; $display("FAIL reset_ram_wr: got %b want 0", ram_wr_o); end
    checks++; if (ram_addr_o !== 32'h0) begin errors++; $display("FAIL reset_ram_addr: got %h want 0", ram_addr_o); end
    checks++; if ({if_done_o, mem_done_o} !== 2'b00) begin errors++; $display("FAIL reset_done: got %b want 00", {if_done_o, mem_done_o}); end
    checks++; if (if_data_o !== 32'h0 || mem_rdata_o !== 32'h0) begin errors++; $display("FAIL reset_data: got %h/%h want 0/0", if_data_o, mem_rdata_o); end
    rst_in = 1'b0;
    tick();
  endtask

  task automatic test_if_read();
    int n;
    if_req_i = 1'b1; if_addr_i = 32'h0000_0100;
    tick();
    checks++; if (ram_addr_o !== 32'h0000_0100) begin errors++; $display("FAIL if_grant_addr: got %h want 00000100", ram_addr_o); end
    wait_done(0, 20, n);
    checks++; if (n !== 5) begin errors++; $display("FAIL if_latency: got %0d want 5", n); end
    checks++; if (if_data_o !== 32'h0000_0513) begin errors++; $display("FAIL if_data: got %h want 00000513", if_data_o); end
    if_req_i = 1'b0;
    tick();
    checks++; if (if_done_o !== 1'b0) begin errors++; $display("FAIL if_done_pulse: got %b want 0", if_done_o); end
    checks++; if (if_data_o !== 32'h0000_0513) begin errors++; $display("FAIL if_data_hold: got %h want 00000513", if_data_o); end
    tick();
  endtask

  task automatic test_priority();
    int n;
    mem_req_i = 1'b1; mem_we_i = 1'b0; mem_size_i = 2'b10; mem_addr_i = 32'h0000_1000;
    if_req_i = 1'b1; if_addr_i = 32'h0000_3000;
    tick();
    checks++; if (ram_addr_o !== 32'h0000_1000) begin errors++; $display("FAIL prio_grant_addr: got %h want 00001000", ram_addr_o); end
    wait_done(2, 20, n);
    checks++; if ({mem_done_o, if_done_o} !== 2'b10) begin errors++; $display("FAIL prio_first: got mem/if %b want 10", {mem_done_o, if_done_o}); end
    checks++; if (n !== 5) begin errors++; $display("FAIL prio_mem_latency: got %0d want 5", n); end
    checks++; if (mem_rdata_o !== 32'hDEAD_BEEF) begin errors++; $display("FAIL prio_mem_data: got %h want deadbeef", mem_rdata_o); end
    mem_req_i = 1'b0;
    wait_done(0, 20, n);
    checks++; if (n !== 8) begin errors++; $display("FAIL prio_if_after_turn: got %0d edges want 8", n); end
    checks++; if (if_data_o !== 32'h4342_4140) begin errors++; $display("FAIL prio_if_data: got %h want 43424140", if_data_o); end
    if_req_i = 1'b0;
    tick(); tick();
  endtask

  task automatic test_store_half();
    int n;
    int base;
    base = wr_cnt;
    mem_req_i = 1'b1; mem_we_i = 1'b1; mem_size_i = 2'b01; mem_addr_i = 32'h0000_2001; mem_wdata_i = 32'hABCD_1234;
    tick();
    checks++; if ({ram_wr_o, ram_addr_o, ram_dout_o, mem_done_o} !== {1'b1, 32'h0000_2001, 8'h34, 1'b0}) begin
      errors++; $display("FAIL st_byte0: got wr=%b addr=%h dout=%h done=%b want 1/00002001/34/0", ram_wr_o, ram_addr_o, ram_dout_o, mem_done_o); end
    wait_done(1, 20, n);
    checks++; if (n !== 1) begin errors++; $display("FAIL st_done_cycle: got %0d want 1", n); end
    checks++; if ({ram_wr_o, ram_addr_o, ram_dout_o} !== {1'b1, 32'h0000_2002, 8'h12}) begin
      errors++; $display("FAIL st_byte1: got wr=%b addr=%h dout=%h want 1/00002002/12", ram_wr_o, ram_addr_o, ram_dout_o); end
    mem_req_i = 1'b0; mem_we_i = 1'b0;
    tick();
    checks++; if (ram_wr_o !== 1'b0) begin errors++; $display("FAIL st_wr_after: got %b want 0", ram_wr_o); end
    checks++; if (wr_cnt - base !== 2) begin errors++; $display("FAIL st_write_count: got %0d want 2", wr_cnt - base); end
    checks++; if ({wr_addr[base], wr_data[base], wr_addr[base+1], wr_data[base+1]} !== {32'h0000_2001, 8'h34, 32'h0000_2002, 8'h12}) begin
      errors++; $display("FAIL st_write_log: got %h:%h %h:%h want 00002001:34 00002002:12", wr_addr[base], wr_data[base], wr_addr[base+1], wr_data[base+1]); end
    tick();
  endtask

  task automatic test_tie_second();
    int n;
    logic exp_if_first;
    exp_if_first = RR;
    mem_req_i = 1'b1; mem_we_i = 1'b0; mem_size_i = 2'b01; mem_addr_i = 32'h0000_1002;
    if_req_i = 1'b1; if_addr_i = 32'h0000_0100;
    tick();
    wait_done(2, 20, n);
    checks++; if (if_done_o !== exp_if_first || mem_done_o !== !exp_if_first) begin
      errors++; $display("FAIL tie_winner: got if=%b mem=%b want if=%b", if_done_o, mem_done_o, exp_if_first); end
    checks++; if (n !== (exp_if_first ? 5 : 3)) begin errors++; $display("FAIL tie_first_latency: got %0d want %0d", n, exp_if_first ? 5 : 3); end
    if (exp_if_first) if_req_i = 1'b0; else mem_req_i = 1'b0;
    wait_done(exp_if_first ? 1 : 0, 20, n);
    checks++; if (n !== (exp_if_first ? 6 : 8)) begin errors++; $display("FAIL tie_second_latency: got %0d want %0d", n, exp_if_first ? 6 : 8); end
    checks++; if (mem_rdata_o !== 32'h0000_DEAD || if_data_o !== 32'h0000_0513) begin
      errors++; $display("FAIL tie_data: got mem=%h if=%h want 0000dead/00000513", mem_rdata_o, if_data_o); end
    if_req_i = 1'b0; mem_req_i = 1'b0;
    tick(); tick();
  endtask

  task automatic test_wrap();
    int n;
    mem_req_i = 1'b1; mem_we_i = 1'b0; mem_size_i = 2'b00; mem_addr_i = 32'hFFFF_FFFF;
    tick();
    checks++; if (ram_addr_o !== 32'hFFFF_FFFF) begin errors++; $display("FAIL wrap_b_addr: got %h want ffffffff", ram_addr_o); end
    wait_done(1, 20, n);
    checks++; if (n !== 2) begin errors++; $display("FAIL wrap_b_latency: got %0d want 2", n); end
    checks++; if (mem_rdata_o !== 32'h0000_0080) begin errors++; $display("FAIL wrap_b_data: got %h want 00000080", mem_rdata_o); end
    mem_req_i = 1'b0;
    tick(); tick();
    mem_req_i = 1'b1; mem_size_i = 2'b01;
    tick();
    tick();
    checks++; if (ram_addr_o !== 32'h0000_0000) begin errors++; $display("FAIL wrap_h_addr: got %h want 00000000", ram_addr_o); end
    wait_done(1, 20, n);
    checks++; if (n !== 2) begin errors++; $display("FAIL wrap_h_latency: got %0d want 2", n); end
    checks++; if (mem_rdata_o !== 32'h0000_7F80) begin errors++; $display("FAIL wrap_h_data: got %h want 00007f80", mem_rdata_o); end
    mem_req_i = 1'b0;
    tick(); tick();
  endtask

  task automatic test_flush();
    int n;
    if_req_i = 1'b1; if_addr_i = 32'h0000_3000;
    tick();
    mem_req_i = 1'b1; mem_we_i = 1'b0; mem_size_i = 2'b10; mem_addr_i = 32'h0000_1000;
    tick();
    tick();
    if_flush_i = 1'b1;
    tick();
    if_flush_i = 1'b0; if_req_i = 1'b0;
    checks++; if (if_done_o !== 1'b0) begin errors++; $display("FAIL flush_no_done_early: got %b want 0", if_done_o); end
    wait_done(2, 20, n);
    checks++; if ({if_done_o, mem_done_o} !== 2'b01) begin errors++; $display("FAIL flush_done_kind: got if/mem %b want 01", {if_done_o, mem_done_o}); end
    checks++; if (n !== 7) begin errors++; $display("FAIL flush_mem_latency: got %0d want 7", n); end
    checks++; if (if_data_o !== 32'h0000_0513) begin errors++; $display("FAIL flush_if_data_kept: got %h want 00000513", if_data_o); end
    checks++; if (mem_rdata_o !== 32'hDEAD_BEEF) begin errors++; $display("FAIL flush_mem_data: got %h want deadbeef", mem_rdata_o); end
    mem_req_i = 1'b0;
    tick(); tick();
  endtask

  task automatic test_reset_mid_write();
    int n;
    int base;
    logic [7:0] exp_b [4];
    exp_b = '{8'h44, 8'h33, 8'h22, 8'h11};
    mem_req_i = 1'b1; mem_we_i = 1'b1; mem_size_i = 2'b10; mem_addr_i = 32'h0000_4000; mem_wdata_i = 32'hCAFE_F00D;
    tick();
    tick();
    checks++; if ({ram_wr_o, ram_dout_o} !== {1'b1, 8'hF0}) begin errors++; $display("FAIL rstw_byte1: got wr=%b dout=%h want 1/f0", ram_wr_o, ram_dout_o); end
    rst_in = 1'b1; mem_req_i = 1'b0; mem_we_i = 1'b0;
    #1;
    checks++; if (ram_wr_o !== 1'b0) begin errors++; $display("FAIL rstw_wr_async: got %b want 0", ram_wr_o); end
    checks++; if (ram_addr_o !== 32'h0) begin errors++; $display("FAIL rstw_addr_async: got %h want 0", ram_addr_o); end
    tick(); tick();
    checks++; if (mem_done_o !== 1'b0) begin errors++; $display("FAIL rstw_no_done: got %b want 0", mem_done_o); end
    rst_in = 1'b0;
    tick();
    checks++; if ({ram_wr_o, mem_done_o} !== 2'b00) begin errors++; $display("FAIL rstw_idle_after: got wr/done %b want 00", {ram_wr_o, mem_done_o}); end
    base = wr_cnt;
    mem_req_i = 1'b1; mem_we_i = 1'b1; mem_size_i = 2'b10; mem_addr_i = 32'h0000_5000; mem_wdata_i = 32'h1122_3344;
    tick();
    checks++; if ({ram_addr_o, ram_dout_o} !== {32'h0000_5000, 8'h44}) begin errors++; $display("FAIL rstw_restart: got %h:%h want 00005000:44", ram_addr_o, ram_dout_o); end
    wait_done(1, 20, n);
    checks++; if (n !== 3) begin errors++; $display("FAIL rstw_done_cycle: got %0d want 3", n); end
    checks++; if ({ram_addr_o, ram_dout_o} !== {32'h0000_5003, 8'h11}) begin errors++; $display("FAIL rstw_last_byte: got %h:%h want 00005003:11", ram_addr_o, ram_dout_o); end
    mem_req_i = 1'b0; mem_we_i = 1'b0;
    tick();
    checks++; if (wr_cnt - base !== 4) begin errors++; $display("FAIL rstw_write_count: got %0d want 4", wr_cnt - base); end
    for (int k = 0; k < 4; k++) begin
      checks++; if (wr_addr[base+k] !== 32'h0000_5000 + k || wr_data[base+k] !== exp_b[k]) begin
        errors++; $display("FAIL rstw_write_log[%0d]: got %h:%h want %h:%h", k, wr_addr[base+k], wr_data[base+k], 32'h0000_5000 + k, exp_b[k]); end
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_if_read();
    test_priority();
    test_store_half();
    test_tie_second();
    test_wrap();
    test_flush();
    test_reset_mid_write();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
